// File: rtl/sa_input_scheduler.sv
// sa_input_scheduler: first stage of the separable switch allocator, one per input port.
// Picks an eligible VC by round-robin, requests its output port, and turns a grant into
// a registered read select plus a VC release pulse on tail flits.
// Optional: define SA_STARVATION_GUARD_EN to add per-VC saturating wait counters that
// override round-robin for a VC that has waited 15 cycles.
module sa_input_scheduler #(
    parameter int VC_NUM   = 2,
    parameter int VC_SIZE  = $clog2(VC_NUM),
    parameter int PORT_NUM = 5,
    parameter int PORT_W   = $clog2(PORT_NUM)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [VC_NUM-1:0]                  vc_ready_i,
    input  logic [VC_NUM-1:0][PORT_W-1:0]      out_port_i,
    input  logic [VC_NUM-1:0][VC_SIZE-1:0]     downstream_vc_i,
    input  logic [PORT_NUM-1:0][VC_NUM-1:0]    on_off_i,
    input  logic [VC_NUM-1:0]                  is_tail_i,
    input  logic                               grant_i,
    output logic [PORT_NUM-1:0]                request_o,
    output logic                               valid_sel_o,
    output logic [VC_SIZE-1:0]                 vc_sel_o,
    output logic [VC_NUM-1:0]                  vc_release_o
);

    localparam logic [PORT_W-1:0] PORT_MAX = PORT_W'(PORT_NUM - 1);

    logic [VC_NUM-1:0]  eligible;
    logic [VC_SIZE-1:0] winner;
    logic               any_elig;
    logic               granted;

    logic               valid_sel_q, valid_sel_d;
    logic [VC_SIZE-1:0] vc_sel_q, vc_sel_d;
    logic [VC_SIZE-1:0] rr_ptr_q, rr_ptr_d;
    logic [VC_NUM-1:0]  vc_release_q, vc_release_d;

`ifdef SA_STARVATION_GUARD_EN
    logic [VC_NUM-1:0][3:0] wait_cnt_q, wait_cnt_d;
`endif

    // A VC may compete if it has a flit, downstream credit, and is not being read right now
    // (its buffer status lags the read by one cycle).
    always_comb begin
        eligible = '0;
        for (int v = 0; v < VC_NUM; v++) begin
            eligible[v] = vc_ready_i[v]
                        && (out_port_i[v] <= PORT_MAX)
                        && on_off_i[out_port_i[v]][downstream_vc_i[v]]
                        && !(valid_sel_q && (vc_sel_q == VC_SIZE'(v)));
        end
    end

    // Round-robin scan starting at rr_ptr; optional starvation override picks lowest saturated VC.
    always_comb begin
        int idx;
        idx      = 0;
        winner   = '0;
        any_elig = 1'b0;
        for (int i = 0; i < VC_NUM; i++) begin
            idx = (int'(rr_ptr_q) + i) % VC_NUM;
            if (!any_elig && eligible[idx]) begin
                any_elig = 1'b1;
                winner   = VC_SIZE'(idx);
            end
        end
`ifdef SA_STARVATION_GUARD_EN
        for (int v = VC_NUM - 1; v >= 0; v--) begin
            if (eligible[v] && (wait_cnt_q[v] == 4'hF)) begin
                winner = VC_SIZE'(v);
            end
        end
`endif
    end

    assign granted = any_elig && grant_i;

    // One-hot request towards the winner's output port; held low while in reset.
    always_comb begin
        request_o = '0;
        if (rst && any_elig) begin
            for (int p = 0; p < PORT_NUM; p++) begin
                request_o[p] = (out_port_i[winner] == PORT_W'(p));
            end
        end
    end

    // Grant turns into a read next cycle; pointer only advances past a granted winner.
    always_comb begin
        valid_sel_d  = granted;
        vc_sel_d     = granted ? winner : vc_sel_q;
        rr_ptr_d     = granted ? VC_SIZE'((int'(winner) + 1) % VC_NUM) : rr_ptr_q;
        vc_release_d = '0;
        if (granted && is_tail_i[winner]) begin
            vc_release_d[winner] = 1'b1;
        end
    end

    // Grant and pointer registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_sel_q  <= 1'b0;
            vc_sel_q     <= '0;
            rr_ptr_q     <= '0;
            vc_release_q <= '0;
        end else begin
            valid_sel_q  <= valid_sel_d;
            vc_sel_q     <= vc_sel_d;
            rr_ptr_q     <= rr_ptr_d;
            vc_release_q <= vc_release_d;
        end
    end

`ifdef SA_STARVATION_GUARD_EN
    // Wait counters: count cycles eligible but passed over, clear on grant or ineligibility.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        for (int v = 0; v < VC_NUM; v++) begin
            if (!eligible[v] || (granted && (winner == VC_SIZE'(v)))) begin
                wait_cnt_d[v] = 4'h0;
            end else if (wait_cnt_q[v] != 4'hF) begin
                wait_cnt_d[v] = wait_cnt_q[v] + 4'h1;
            end
        end
    end

    // Wait counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end
`endif

    assign valid_sel_o  = valid_sel_q;
    assign vc_sel_o     = vc_sel_q;
    assign vc_release_o = vc_release_q;

endmodule

// File: tb/tb_sa_input_scheduler.sv
// Directed bench for sa_input_scheduler: stimulus pushes expected reads into a queue,
// a negedge monitor pops and compares whenever the DUT presents a read.
module tb_sa_input_scheduler;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [1:0]           vc_ready_i;
    logic [1:0][2:0]      out_port_i;
    logic [1:0][0:0]      downstream_vc_i;
    logic [4:0][1:0]      on_off_i;
    logic [1:0]           is_tail_i;
    logic                 grant_i;
    logic [4:0]           request_o;
    logic                 valid_sel_o;
    logic [0:0]           vc_sel_o;
    logic [1:0]           vc_release_o;

    typedef struct {
        logic [0:0] vc;
        logic [1:0] rel;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    sa_input_scheduler dut (
        .clk             (clk),
        .rst             (rst),
        .vc_ready_i      (vc_ready_i),
        .out_port_i      (out_port_i),
        .downstream_vc_i (downstream_vc_i),
        .on_off_i        (on_off_i),
        .is_tail_i       (is_tail_i),
        .grant_i         (grant_i),
        .request_o       (request_o),
        .valid_sel_o     (valid_sel_o),
        .vc_sel_o        (vc_sel_o),
        .vc_release_o    (vc_release_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [0:0] vc, input logic [1:0] rel);
        exp_t e;
        e.vc  = vc;
        e.rel = rel;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Check the combinational request for the current inputs, then advance one cycle.
    task automatic step(input string name, input logic [4:0] exp_req);
        #2;
        chk(name, request_o, exp_req);
        tick();
    endtask

    // Monitor: every read is matched against the next expected entry; idle cycles carry no release.
    always @(negedge clk) begin
        if (rst) begin
            if (valid_sel_o) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_read: got vc %0d with nothing expected at %0t",
                             vc_sel_o, $time);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("mon_vc_sel", vc_sel_o, e.vc);
                    chk("mon_release", vc_release_o, e.rel);
                end
            end else begin
                chk("mon_release_idle", vc_release_o, 0);
            end
        end
    end

    initial begin
        // Reset held with every input active.
        rst             = 1'b0;
        vc_ready_i      = 2'b11;
        out_port_i[0]   = 3'd1;
        out_port_i[1]   = 3'd1;
        downstream_vc_i = '{1'b1, 1'b0};
        on_off_i        = '1;
        is_tail_i       = 2'b11;
        grant_i         = 1'b1;
        tick();
        tick();
        #2;
        chk("rst_request", request_o, 0);
        chk("rst_valid", valid_sel_o, 0);
        chk("rst_release", vc_release_o, 0);
        tick();

        // Release reset: request appears in the same cycle.
        rst     = 1'b1;
        grant_i = 1'b0;
        step("post_rst_req", 5'b00010);

        // Single VC to EAST.
        vc_ready_i         = 2'b10;
        out_port_i[1]      = 3'd4;
        downstream_vc_i[1] = 1'b0;
        on_off_i           = '0;
        on_off_i[4][0]     = 1'b1;
        is_tail_i          = 2'b00;
        grant_i            = 1'b1;
        push(1'b1, 2'b00);
        step("single_req", 5'b10000);
        step("single_blocked", 5'b00000);
        vc_ready_i = 2'b00;
        grant_i    = 1'b0;
        step("single_idle", 5'b00000);

        // Fairness: both VCs to NORTH, permanent grant.
        vc_ready_i      = 2'b11;
        out_port_i[0]   = 3'd1;
        out_port_i[1]   = 3'd1;
        downstream_vc_i = '{1'b1, 1'b0};
        on_off_i        = '1;
        grant_i         = 1'b1;
        push(1'b0, 2'b00); step("rr_a_vc0", 5'b00010);
        push(1'b1, 2'b00); step("rr_b_vc1", 5'b00010);
        push(1'b0, 2'b00); step("rr_c_vc0", 5'b00010);
        push(1'b1, 2'b00); step("rr_d_vc1", 5'b00010);
        vc_ready_i = 2'b00;
        grant_i    = 1'b0;
        step("rr_drain", 5'b00000);

        // Backpressure on VC0's downstream VC.
        out_port_i[0]      = 3'd2;
        downstream_vc_i[0] = 1'b1;
        out_port_i[1]      = 3'd1;
        downstream_vc_i[1] = 1'b0;
        on_off_i           = '1;
        on_off_i[2][1]     = 1'b0;
        vc_ready_i         = 2'b11;
        grant_i            = 1'b1;
        push(1'b1, 2'b00);
        step("bp_only_vc1", 5'b00010);
        on_off_i[2][1] = 1'b1;
        push(1'b0, 2'b00);
        step("bp_restored_vc0", 5'b00100);
        vc_ready_i = 2'b00;
        grant_i    = 1'b0;
        step("bp_drain", 5'b00000);

        // Grant loss: pointer at VC1 must survive three lost cycles.
        vc_ready_i         = 2'b11;
        out_port_i[0]      = 3'd3;
        downstream_vc_i[0] = 1'b0;
        out_port_i[1]      = 3'd4;
        downstream_vc_i[1] = 1'b0;
        grant_i            = 1'b0;
        for (int i = 0; i < 3; i++) step("loss_hold", 5'b10000);
        grant_i = 1'b1;
        push(1'b1, 2'b00);
        step("loss_grant", 5'b10000);
        vc_ready_i = 2'b00;
        grant_i    = 1'b0;
        step("loss_drain", 5'b00000);

        // Tail on VC0 then VC1: one-cycle release aligned with the read.
        vc_ready_i = 2'b01;
        is_tail_i  = 2'b01;
        grant_i    = 1'b1;
        push(1'b0, 2'b01);
        step("tail0_req", 5'b01000);
        vc_ready_i = 2'b00;
        grant_i    = 1'b0;
        is_tail_i  = 2'b00;
        step("tail0_after", 5'b00000);
        vc_ready_i = 2'b10;
        is_tail_i  = 2'b10;
        grant_i    = 1'b1;
        push(1'b1, 2'b10);
        step("tail1_req", 5'b10000);
        vc_ready_i = 2'b00;
        grant_i    = 1'b0;
        is_tail_i  = 2'b00;
        step("tail1_after", 5'b00000);

        // Reset mid-read aborts outputs immediately.
        vc_ready_i = 2'b01;
        is_tail_i  = 2'b01;
        grant_i    = 1'b1;
        step("mid_req", 5'b01000);
        chk("mid_valid_before", valid_sel_o, 1);
        chk("mid_release_before", vc_release_o, 2'b01);
        grant_i = 1'b0;
        #1 rst = 1'b0;
        #1;
        chk("mid_valid_abort", valid_sel_o, 0);
        chk("mid_release_abort", vc_release_o, 0);
        chk("mid_request_abort", request_o, 0);
        tick();
        rst = 1'b1;
        step("mid_post_rst", 5'b01000);
        vc_ready_i = 2'b00;
        is_tail_i  = 2'b00;
        tick();
        tick();

        chk("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sa_input_scheduler.md
Name: sa_input_scheduler

Overview:
- Per-input-port first stage of the separable switch allocator.
- Each cycle it picks one eligible virtual channel of its input port by round-robin and raises a one-hot request towards the selected output port's arbiter.
- On grant, it drives the read select (valid_sel / vc_sel) of its input port one cycle later and pulses a VC release when a tail flit is read.
- One instance sits beside each input port, between the input buffers and the per-output second-stage arbiters.

Parameters:
- VC_NUM, 2, number of virtual channels per input port (from noc_params).
- VC_SIZE, $clog2(VC_NUM), width of a VC index.
- PORT_NUM, 5, number of router ports (LOCAL, NORTH, SOUTH, WEST, EAST); port_t encodes 0..PORT_NUM-1.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  asynchronous reset, active-low.
- vc_ready_i  input  [VC_NUM]  VC holds a flit and has a downstream VC allocated.
- out_port_i  input  port_t[VC_NUM]  routed output port per VC.
- downstream_vc_i  input  [VC_NUM][VC_SIZE]  allocated downstream VC per VC.
- on_off_i  input  [PORT_NUM][VC_NUM]  downstream on/off flow control, 1 = may send.
- is_tail_i  input  [VC_NUM]  head-of-buffer flit of the VC is a tail (or head-tail).
- grant_i  input  1  second-stage arbiter granted this port's current request, same cycle.
- request_o  output  [PORT_NUM]  one-hot request to output port arbiters.
- valid_sel_o  output  1  read strobe to input port.
- vc_sel_o  output  [VC_SIZE]  VC to read.
- vc_release_o  output  [VC_NUM]  one-cycle pulse; VC finished its packet and is allocatable again.

Behaviour:
- Reset (rst=0, async): valid_sel_o=0, vc_sel_o=0, vc_release_o=0, round-robin pointer rr_ptr=0, and request_o=0 (forced combinationally while reset is asserted).
- Eligibility: eligible[v] = vc_ready_i[v] & on_off_i[out_port_i[v]][downstream_vc_i[v]] & ~(valid_sel_o & vc_sel_o==v).
  - The last term blocks back-to-back selection of the VC being read this cycle; its empty status is stale by one cycle.
- Stage 1, combinational: winner = first eligible VC scanning rr_ptr, rr_ptr+1, ... modulo VC_NUM (wrap-around).
  - If any VC is eligible, request_o is one-hot at out_port_i[winner]; otherwise request_o = 0.
- Grant, registered with 1-cycle latency:
  - If request_o != 0 and grant_i=1: next cycle valid_sel_o=1, vc_sel_o=winner, and rr_ptr <= (winner+1) mod VC_NUM.
  - Else: valid_sel_o=0, vc_sel_o holds its value, rr_ptr unchanged (no pointer update on loss).
- grant_i while request_o=0 is ignored.
- Release: vc_release_o[w] pulses for one cycle, in the same cycle as valid_sel_o, for the granted VC w when is_tail_i[w] was 1 at grant time (sampled and registered with the grant).
- Simultaneous events:
  - All VCs eligible: pure rotation, one grant per cycle at most.
  - A VC whose on_off drops in the request cycle is not requested that cycle.
  - on_off changing after grant does not cancel the read.
- No internal FSM beyond the pointer and grant registers. Reset mid-operation aborts any pending read: outputs return to reset values immediately.

Optional Feature:
- Macro SA_STARVATION_GUARD_EN.
- When defined:
  - Per-VC 4-bit saturating wait counter: increments each cycle the VC is eligible but not granted; clears on grant or when the VC is not eligible.
  - While any counter equals 15, the lowest-index saturated VC overrides round-robin as winner.
  - Counters reset to 0.
- When undefined: pure round-robin, no counters synthesized.

Test Plan:
- Reset: hold rst=0 with all inputs active -> request_o=0, valid_sel_o=0, vc_release_o=0; release rst -> first request appears the same cycle inputs allow.
- Single VC: vc_ready_i=2'b10, out_port_i[1]=EAST(4), downstream_vc_i[1]=0, on_off_i[4][0]=1, grant_i=1 -> request_o=5'b10000, next cycle valid_sel_o=1 and vc_sel_o=1; cycle after, VC1 not requested.
- Fairness: both VCs ready to port NORTH, grant_i=1 permanently -> grants alternate 0,1,0,1 with a one-cycle bubble rule respected (VC reselected only after a skip cycle).
- Backpressure: on_off_i[out_port_i[0]][downstream_vc_i[0]]=0, VC1 ready -> only VC1 requested; restore on_off -> VC0 requested on the next rr turn.
- Grant loss: request held with grant_i=0 for 3 cycles -> valid_sel_o stays 0 and rr_ptr is unchanged; grant_i=1 -> same VC read.
- Tail: grant on VC0 with is_tail_i[0]=1 -> vc_release_o=2'b01 for exactly one cycle, aligned with valid_sel_o.
